// File: rtl/hbus_arb_pkg.sv
// Shared types and default sizes for the hart-to-L3 bus arbiter.
package hbus_arb_pkg;

  // Default hart count and bus line width.
  localparam int unsigned HBUS_HARTS = 4;
  localparam int unsigned HMEM_LINE  = 128;
  localparam int unsigned ADDR_W     = 64;

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/hbus_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr_i (wrapping) wins.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot grant,
//        any_o high when any request is present.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          any_o
);

  logic [IW-1:0] idx;
  logic          found;

  // Walk N positions starting at the pointer; first hit is granted.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/hbus_arb.sv
// Arbitrates HARTS hart L2 ports onto a single L3 line bus.
// Each hart owns a one-entry write-through buffer; writes win over reads
// within a hart, harts are served round-robin, one L3 transaction at a time.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   h_addr/h_rd/h_wr         per-hart address, read level, write pulse
//   h_data_out               per-hart write line (valid with h_wr)
//   h_data_in/h_dv           broadcast read line, per-hart read valid
//   inv/inv_addr             invalidate pulse to the other harts on a write
//   wb_ovf                   sticky per-hart write-buffer overflow
//   m_addr/m_rd/m_wr         L3 request
//   m_data_out/m_data_in     L3 write/read line
//   m_dv                     L3 completion
module hbus_arb
  import hbus_arb_pkg::*;
#(
  parameter int unsigned HARTS = HBUS_HARTS,
  parameter int unsigned LINE  = HMEM_LINE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W*HARTS-1:0] h_addr,
  input  logic [HARTS-1:0]        h_rd,
  input  logic [HARTS-1:0]        h_wr,
  input  logic [LINE*HARTS-1:0]   h_data_out,
  output logic [LINE-1:0]         h_data_in,
  output logic [HARTS-1:0]        h_dv,
  output logic [HARTS-1:0]        inv,
  output logic [ADDR_W-1:0]       inv_addr,
  output logic [HARTS-1:0]        wb_ovf,
  output logic [ADDR_W-1:0]       m_addr,
  output logic                    m_rd,
  output logic                    m_wr,
  output logic [LINE-1:0]         m_data_out,
  input  logic [LINE-1:0]         m_data_in,
  input  logic                    m_dv
);

  localparam int unsigned IW = (HARTS > 1) ? $clog2(HARTS) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic              wr_op_q, wr_op_d;

  logic [HARTS-1:0]  wb_v_q;
  logic [HARTS-1:0]  wb_ovf_q;
  logic [ADDR_W-1:0] wb_addr_q [HARTS];
  logic [LINE-1:0]   wb_line_q [HARTS];

  logic [LINE-1:0]   h_data_in_q, h_data_in_d;
  logic [HARTS-1:0]  h_dv_q, h_dv_d;
  logic [HARTS-1:0]  inv_q, inv_d;
  logic [ADDR_W-1:0] inv_addr_q, inv_addr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_rd_q, m_rd_d;
  logic              m_wr_q, m_wr_d;
  logic [LINE-1:0]   m_data_out_q, m_data_out_d;

  logic [ADDR_W-1:0] h_addr_a [HARTS];
  logic [HARTS-1:0]  req_c;
  logic [HARTS-1:0]  pick_gnt;
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic              wb_done_c;

  // Unpack per-hart addresses.
  always_comb begin
    for (int unsigned k = 0; k < HARTS; k++) begin
      h_addr_a[k] = h_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign req_c     = wb_v_q | h_rd;
  assign wb_done_c = (state_q == ST_BUSY) && wr_op_q && m_dv;

  rr_pick #(
    .N  (HARTS),
    .IW (IW)
  ) u_pick (
    .req_i (req_c),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  // One-hot grant to index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned k = 0; k < HARTS; k++) begin
      if (pick_gnt[k]) pick_idx = IW'(k);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    wr_op_d      = wr_op_q;
    h_data_in_d  = h_data_in_q;
    h_dv_d       = '0;
    inv_d        = '0;
    inv_addr_d   = inv_addr_q;
    m_addr_d     = m_addr_q;
    m_rd_d       = m_rd_q;
    m_wr_d       = m_wr_q;
    m_data_out_d = m_data_out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          gnt_d   = pick_idx;
          ptr_d   = (pick_idx == IW'(HARTS - 1)) ? '0 : pick_idx + IW'(1);
          wr_op_d = wb_v_q[pick_idx];
          if (wb_v_q[pick_idx]) begin
            m_wr_d       = 1'b1;
            m_addr_d     = wb_addr_q[pick_idx];
            m_data_out_d = wb_line_q[pick_idx];
            inv_d        = ~pick_gnt;
            inv_addr_d   = wb_addr_q[pick_idx];
          end else begin
            m_rd_d   = 1'b1;
            m_addr_d = h_addr_a[pick_idx];
          end
        end
      end
      ST_BUSY: begin
        if (m_dv) begin
          m_rd_d = 1'b0;
          m_wr_d = 1'b0;
          if (wr_op_q) begin
            state_d = ST_IDLE;
          end else begin
            h_data_in_d = m_data_in;
            // A hart that dropped its read while waiting loses the line.
            if (h_rd[gnt_q]) begin
              state_d       = ST_RESP;
              h_dv_d[gnt_q] = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_RESP: begin
        if (h_rd[gnt_q]) h_dv_d[gnt_q] = 1'b1;
        else             state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      wr_op_q      <= 1'b0;
      h_data_in_q  <= '0;
      h_dv_q       <= '0;
      inv_q        <= '0;
      inv_addr_q   <= '0;
      m_addr_q     <= '0;
      m_rd_q       <= 1'b0;
      m_wr_q       <= 1'b0;
      m_data_out_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      wr_op_q      <= wr_op_d;
      h_data_in_q  <= h_data_in_d;
      h_dv_q       <= h_dv_d;
      inv_q        <= inv_d;
      inv_addr_q   <= inv_addr_d;
      m_addr_q     <= m_addr_d;
      m_rd_q       <= m_rd_d;
      m_wr_q       <= m_wr_d;
      m_data_out_q <= m_data_out_d;
    end
  end

  // Write-buffer control: a new write always lands; it only counts as an
  // overflow if the old entry is not retiring in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_v_q   <= '0;
      wb_ovf_q <= '0;
    end else begin
      for (int unsigned k = 0; k < HARTS; k++) begin
        if (h_wr[k]) begin
          wb_v_q[k] <= 1'b1;
          if (wb_v_q[k] && !(wb_done_c && (gnt_q == IW'(k)))) wb_ovf_q[k] <= 1'b1;
        end else if (wb_done_c && (gnt_q == IW'(k))) begin
          wb_v_q[k] <= 1'b0;
        end
      end
    end
  end

  // Write-buffer payload; qualified by wb_v_q so no reset needed.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < HARTS; k++) begin
      if (h_wr[k]) begin
        wb_addr_q[k] <= h_addr_a[k];
        wb_line_q[k] <= h_data_out[k*LINE +: LINE];
      end
    end
  end

  assign h_data_in  = h_data_in_q;
  assign h_dv       = h_dv_q;
  assign inv        = inv_q;
  assign inv_addr   = inv_addr_q;
  assign wb_ovf     = wb_ovf_q;
  assign m_addr     = m_addr_q;
  assign m_rd       = m_rd_q;
  assign m_wr       = m_wr_q;
  assign m_data_out = m_data_out_q;

endmodule
